alu_cmd_feeder: RTL and testbench
=================================

ALU_CMD_FEEDER -- requirements
Module: alu_cmd_feeder

Interface
REQ-001 The block SHALL have one parameter: DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  asynchronous active-high reset.
REQ-005 In_valid  input  1  upstream command present.
REQ-006 In_ready  output  1  FIFO can accept a command this cycle.
REQ-007 In_data  input  4  operand for the downstream ALU Data input.
REQ-008 In_func  input  3  opcode for the downstream ALU Function input.
REQ-009 Go  input  1  level: continuous issue enable.
REQ-010 Step  input  1  single-cycle pulse: issue one command while Go=0.
REQ-011 Clear  input  1  synchronous flush plus accumulator clear request.
REQ-012 Data  output  4  registered operand to the ALU/accumulator stage.
REQ-013 Function  output  3  registered opcode to the ALU/accumulator stage.
REQ-014 Acc_clear_b  output  1  registered active-low clear to the accumulator's Reset_b.
REQ-015 Issue  output  1  high in each cycle Data/Function carry a real command.
REQ-016 Count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 Issued_cnt  output  8  commands issued since reset/Clear.

Function
REQ-018 In_ready SHALL equal (Count < DEPTH), computed from pre-edge occupancy; push on a full FIFO is refused even if a pop occurs in the same cycle.
REQ-019 A push SHALL occur on an edge where In_valid=1 and In_ready=1; {In_data,In_func} is stored in FIFO order.
REQ-020 The FSM SHALL have states IDLE and RUN: IDLE->RUN when Go=1; RUN->IDLE when Go=0; Clear forces IDLE.
REQ-021 Pop condition: FIFO non-empty and Clear=0 and (state RUN with Go=1, or state IDLE with Step=1).
REQ-022 On a pop edge, Data/Function SHALL take the head entry and Issue SHALL be 1 for exactly that following cycle.
REQ-023 On every non-pop edge, Data SHALL be 4'b0000, Function SHALL be 3'b111 (accumulator hold), and Issue SHALL be 0.
REQ-024 Minimum latency SHALL be one cycle: a command pushed at edge k SHALL appear no earlier than after edge k+1; no FIFO bypass.
REQ-025 In RUN with continuous Go=1 and a non-empty FIFO, one command SHALL issue per cycle with no bubbles.
REQ-026 Simultaneous push and pop on a non-full FIFO SHALL leave Count unchanged.
REQ-027 Go falling SHALL stop popping at that edge; the head entry is retained.
REQ-028 Step while Go=1, or Step while the FIFO is empty, SHALL have no effect; Step held high for N cycles in IDLE SHALL issue N commands.
REQ-029 Clear SHALL take priority over push and pop: on a Clear edge the FIFO empties, Count=0, Issued_cnt=0, the outputs take hold values, and Acc_clear_b=0 for exactly the next cycle.
REQ-030 Issued_cnt SHALL increment on each pop and wrap from 255 to 0.
REQ-031 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-032 While Reset=1, the block SHALL hold: FIFO empty, Count=0, state IDLE, Data=0, Function=3'b111, Issue=0, Issued_cnt=0, Acc_clear_b=0.
REQ-033 After Reset falls, Acc_clear_b SHALL go to 1 on the first rising edge.
REQ-034 Reset asserted mid-operation SHALL discard all queued commands immediately, without waiting for a clock edge.

Verification
REQ-035 Reset, push (3,000), (5,000), (2,001) with Go=0, then Go=1 -> three consecutive Issue cycles carry Data 3,5,2 and Function 000,000,001, then Function=111; Issued_cnt=3.
REQ-036 Push 5 commands with DEPTH=4 and Go=0 -> In_ready=0 after the 4th push, the 5th is held; Count=4. Then Go=1 -> the 5th is accepted one cycle after the first pop.
REQ-037 Go=0, FIFO holds 2 entries, Step pulsed once -> exactly one Issue and Count=1. Step during Go=1 -> no extra pop.
REQ-038 Go=1 while 3 entries are queued, Clear asserted for one edge -> Count=0, Issue=0, Function=111, Acc_clear_b low for one cycle; a push in the same cycle is dropped.
REQ-039 Issue 256 commands -> Issued_cnt wraps to 0; FIFO pointers wrap with no data corruption, checked against a scoreboard.
REQ-040 Assert Reset asynchronously between edges while RUN is issuing -> outputs go to their reset values before the next edge.

Source files
------------

// File: rtl/alu_cmd_feeder.sv
// Command FIFO that feeds registered operand/opcode pairs to a downstream ALU/accumulator,
// with continuous (go) or single-step issue, flush/clear, and an issued-command counter.
module alu_cmd_feeder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_data,
    input  logic [2:0]               in_func,
    input  logic                     go,
    input  logic                     step,
    input  logic                     clear,
    output logic [3:0]               data,
    output logic [2:0]               func,
    output logic                     acc_clear_b,
    output logic                     issue,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               issued_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 7;
    localparam logic [2:0]  FUNC_HOLD = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      data_q, data_d;
    logic [2:0]      func_q, func_d;
    logic            issue_q, issue_d;
    logic            acc_clear_b_q, acc_clear_b_d;
    logic [7:0]      issued_cnt_q, issued_cnt_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic            push_c, pop_c;

    // Ready is decoded from pre-edge occupancy, so a full FIFO refuses a push even when popping.
    assign in_ready = (count_q < CW'(DEPTH));

    always_comb begin
        push_c = in_valid && in_ready && !clear;
        pop_c  = (count_q != '0) && !clear &&
                 ((state_q == RUN && go) || (state_q == IDLE && step && !go));

        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        data_d        = 4'b0000;
        func_d        = FUNC_HOLD;
        issue_d       = 1'b0;
        acc_clear_b_d = !clear;
        issued_cnt_d  = issued_cnt_q;

        case (state_q)
            IDLE:    if (go)  state_d = RUN;
            RUN:     if (!go) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d      = IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            issued_cnt_d = 8'd0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c) begin
                rd_ptr_d     = rd_ptr_q + PW'(1);
                {data_d, func_d} = mem_q[rd_ptr_q];
                issue_d      = 1'b1;
                issued_cnt_d = issued_cnt_q + 8'd1;
            end
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // Storage array needs no reset: occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= {in_data, in_func};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            data_q        <= 4'b0000;
            func_q        <= FUNC_HOLD;
            issue_q       <= 1'b0;
            acc_clear_b_q <= 1'b0;
            issued_cnt_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            data_q        <= data_d;
            func_q        <= func_d;
            issue_q       <= issue_d;
            acc_clear_b_q <= acc_clear_b_d;
            issued_cnt_q  <= issued_cnt_d;
        end
    end

    assign data        = data_q;
    assign func        = func_q;
    assign issue       = issue_q;
    assign acc_clear_b = acc_clear_b_q;
    assign count       = count_q;
    assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_alu_cmd_feeder.sv
// Directed vector table plus hand sequences (step burst, 256-command wrap, async reset)
// for alu_cmd_feeder with DEPTH=4.
module tb_alu_cmd_feeder;

    logic       clk, rst, in_valid, in_ready, go, step, clear;
    logic [3:0] in_data, data;
    logic [2:0] in_func, func;
    logic       acc_clear_b, issue;
    logic [2:0] count;
    logic [7:0] issued_cnt;

    int n_vec = 0;
    int n_err = 0;

    alu_cmd_feeder #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_func(in_func), .go(go), .step(step), .clear(clear),
        .data(data), .func(func), .acc_clear_b(acc_clear_b), .issue(issue),
        .count(count), .issued_cnt(issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [3:0] d; logic [2:0] f; logic g; logic s; logic c;
        logic rdy; logic [3:0] ed; logic [2:0] ef; logic eiss; int ecnt; int eic; logic eacb;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic v, input logic [3:0] d, input logic [2:0] f,
                       input logic g, input logic s, input logic c,
                       input logic rdy, input logic [3:0] ed, input logic [2:0] ef,
                       input logic eiss, input int ecnt, input int eic, input logic eacb);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.g = g; t.s = s; t.c = c;
        t.rdy = rdy; t.ed = ed; t.ef = ef; t.eiss = eiss; t.ecnt = ecnt; t.eic = eic; t.eacb = eacb;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic [3:0] ed,
                           input logic [2:0] ef, input logic eiss, input int ecnt,
                           input int eic, input logic eacb);
        chk({tag, ".ready"}, int'(in_ready), int'(rdy));
        chk({tag, ".data"}, int'(data), int'(ed));
        chk({tag, ".func"}, int'(func), int'(ef));
        chk({tag, ".issue"}, int'(issue), int'(eiss));
        chk({tag, ".count"}, int'(count), ecnt);
        chk({tag, ".issued"}, int'(issued_cnt), eic);
        chk({tag, ".acb"}, int'(acc_clear_b), int'(eacb));
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic [2:0] f,
                         input logic g, input logic s, input logic c);
        in_valid = v; in_data = d; in_func = f; go = g; step = s; clear = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pushed, pops, cyc;
        bit acc;
        logic [6:0] sb[$];
        logic [6:0] exp_e;

        rst = 1'b1;
        drive(0, 4'd0, 3'd0, 0, 0, 0);
        tick(); tick();
        chk_all("reset", 1, 4'd0, 3'd7, 0, 0, 0, 0);
        rst = 1'b0;

        //   v  d  f  g  s  c   rdy ed ef iss cnt ic acb
        add(0, 0, 0, 0, 0, 0,   1, 0, 7, 0, 0, 0, 1);
        add(1, 3, 0, 0, 0, 0,   1, 0, 7, 0, 1, 0, 1);
        add(1, 5, 0, 0, 0, 0,   1, 0, 7, 0, 2, 0, 1);
        add(1, 2, 1, 0, 0, 0,   1, 0, 7, 0, 3, 0, 1);
        add(0, 0, 0, 1, 0, 0,   1, 0, 7, 0, 3, 0, 1);
        add(0, 0, 0, 1, 0, 0,   1, 3, 0, 1, 2, 1, 1);
        add(0, 0, 0, 1, 0, 0,   1, 5, 0, 1, 1, 2, 1);
        add(0, 0, 0, 1, 0, 0,   1, 2, 1, 1, 0, 3, 1);
        add(0, 0, 0, 1, 0, 0,   1, 0, 7, 0, 0, 3, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 7, 0, 0, 3, 1);
        // fill to full, fifth command held
        add(1, 1, 2, 0, 0, 0,   1, 0, 7, 0, 1, 3, 1);
        add(1, 4, 3, 0, 0, 0,   1, 0, 7, 0, 2, 3, 1);
        add(1, 6, 4, 0, 0, 0,   1, 0, 7, 0, 3, 3, 1);
        add(1, 7, 5, 0, 0, 0,   0, 0, 7, 0, 4, 3, 1);
        add(1, 9, 6, 0, 0, 0,   0, 0, 7, 0, 4, 3, 1);
        add(1, 9, 6, 1, 0, 0,   0, 0, 7, 0, 4, 3, 1);
        add(1, 9, 6, 1, 0, 0,   1, 1, 2, 1, 3, 4, 1);
        add(1, 9, 6, 1, 0, 0,   1, 4, 3, 1, 3, 5, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 7, 0, 3, 5, 1);
        // single step, then step ignored while go is high
        add(0, 0, 0, 0, 1, 0,   1, 6, 4, 1, 2, 6, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 7, 0, 2, 6, 1);
        add(0, 0, 0, 0, 1, 0,   1, 7, 5, 1, 1, 7, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 7, 0, 1, 7, 1);
        add(0, 0, 0, 1, 1, 0,   1, 0, 7, 0, 1, 7, 1);
        add(0, 0, 0, 1, 1, 0,   1, 9, 6, 1, 0, 8, 1);
        add(0, 0, 0, 1, 0, 0,   1, 0, 7, 0, 0, 8, 1);
        // clear while running with queued commands; same-cycle push dropped
        add(1, 1, 0, 0, 0, 0,   1, 0, 7, 0, 1, 8, 1);
        add(1, 2, 0, 0, 0, 0,   1, 0, 7, 0, 2, 8, 1);
        add(1, 3, 0, 0, 0, 0,   1, 0, 7, 0, 3, 8, 1);
        add(1, 4, 0, 1, 0, 0,   0, 0, 7, 0, 4, 8, 1);
        add(0, 0, 0, 1, 0, 0,   1, 1, 0, 1, 3, 9, 1);
        add(1, 5, 1, 1, 0, 1,   1, 0, 7, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0,   1, 0, 7, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 7, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].g, vecs[i].s, vecs[i].c);
            tick();
            chk_all($sformatf("v%0d", i), vecs[i].rdy, vecs[i].ed, vecs[i].ef,
                    vecs[i].eiss, vecs[i].ecnt, vecs[i].eic, vecs[i].eacb);
        end

        // step held high for three cycles issues three commands, then nothing when empty
        drive(1, 4'd8, 3'd1, 0, 0, 0);  tick();
        drive(1, 4'd10, 3'd2, 0, 0, 0); tick();
        drive(1, 4'd12, 3'd3, 0, 0, 0); tick();
        drive(0, 4'd0, 3'd0, 0, 1, 0);
        tick(); chk_all("step1", 1, 4'd8, 3'd1, 1, 2, 1, 1);
        tick(); chk_all("step2", 1, 4'd10, 3'd2, 1, 1, 2, 1);
        tick(); chk_all("step3", 1, 4'd12, 3'd3, 1, 0, 3, 1);
        tick(); chk_all("step4", 1, 4'd0, 3'd7, 0, 0, 3, 1);

        drive(0, 4'd0, 3'd0, 0, 0, 1); tick();
        chk("pre_wrap.issued", int'(issued_cnt), 0);
        drive(0, 4'd0, 3'd0, 0, 0, 0); tick();

        // 256 commands through the FIFO against a scoreboard
        pushed = 0; pops = 0; cyc = 0;
        while (pops < 256 && cyc < 800) begin
            drive(pushed < 256, 4'(pushed), 3'(pushed / 16), 1, 0, 0);
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                sb.push_back({in_data, in_func});
                pushed++;
            end
            if (issue) begin
                if (sb.size() == 0) begin
                    chk("wrap.unexpected_issue", 1, 0);
                end else begin
                    exp_e = sb.pop_front();
                    if ({data, func} != exp_e) chk($sformatf("wrap.entry%0d", pops), int'({data, func}), int'(exp_e));
                    pops++;
                    if (pops == 255) chk("wrap.issued255", int'(issued_cnt), 255);
                end
            end
        end
        chk("wrap.pops", pops, 256);
        chk("wrap.issued", int'(issued_cnt), 0);
        chk("wrap.count", int'(count), 0);

        // async reset between edges while issuing
        drive(1, 4'd10, 3'd2, 1, 0, 0); tick();
        tick();
        chk("arst.pre_issue", int'(issue), 1);
        chk("arst.pre_data", int'(data), 10);
        drive(0, 4'd0, 3'd0, 1, 0, 0);
        #2 rst = 1'b1;
        #1 chk_all("arst.now", 1, 4'd0, 3'd7, 0, 0, 0, 0);
        tick();
        chk_all("arst.held", 1, 4'd0, 3'd7, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 4'd0, 3'd0, 0, 0, 0);
        tick();
        chk_all("arst.release", 1, 4'd0, 3'd7, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
